// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding,
// default program-length limit and the word-address helper.
package loader_pkg;

  localparam int MAX_WORDS_DEFAULT = 1024;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_WRITE = 3'd3,
    ST_VRD   = 3'd4,
    ST_VCHK  = 3'd5,
    ST_DONE  = 3'd6,
    ST_ERR   = 3'd7
  } state_t;

  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + {idx[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Collects a big-endian byte stream into 32-bit words; word_ready marks the
// cycle in which the fourth byte is accepted, with the full word on word_next.
module byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  data,
  output logic [31:0] word_next,
  output logic        word_ready
);

  logic [1:0]  cnt_r;
  logic [23:0] part_r;

  // The fourth byte is merged combinationally so the word is usable in the accept cycle.
  assign word_next  = {part_r, data};
  assign word_ready = byte_en && (cnt_r == 2'd3);

  // Byte counter and partial-word shift register; both hold while no byte transfers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r  <= 2'd0;
      part_r <= 24'd0;
    end else if (clear) begin
      cnt_r  <= 2'd0;
      part_r <= 24'd0;
    end else if (byte_en) begin
      cnt_r  <= cnt_r + 2'd1;
      part_r <= {part_r[15:0], data};
    end else begin
      cnt_r  <= cnt_r;
      part_r <= part_r;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed program into instruction memory, reads it back to
// verify an XOR checksum, and holds the CPU fetch stage until the load is good.
module imem_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h00000000,
  parameter int          MAX_WORDS = MAX_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_cs,
  output logic        mem_oe,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam int WCW = $clog2(MAX_WORDS + 1);

  state_t           state_r, next_state_s;
  logic [WCW-1:0]   k_r, k_s, n_r, n_s;
  logic [31:0]      csum_r, csum_s, rb_r, rb_s;
  logic             done_s, error_s;
  logic             cs_s, oe_s, we_s;
  logic [31:0]      addr_s, din_s;
  logic             clear_s, byte_en_s, word_ready_s;
  logic [31:0]      word_next_s;

  assign byte_en_s = in_valid && in_ready;

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear_s),
    .byte_en    (byte_en_s),
    .data       (in_data),
    .word_next  (word_next_s),
    .word_ready (word_ready_s)
  );

  // Next-state, datapath and next memory-strobe computation.
  always_comb begin
    next_state_s = state_r;
    k_s          = k_r;
    n_s          = n_r;
    csum_s       = csum_r;
    rb_s         = rb_r;
    done_s       = done;
    error_s      = error;
    cs_s         = 1'b0;
    oe_s         = 1'b0;
    we_s         = 1'b0;
    addr_s       = 32'd0;
    din_s        = 32'd0;
    clear_s      = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          next_state_s = ST_HDR;
          k_s          = '0;
          n_s          = '0;
          csum_s       = 32'd0;
          rb_s         = 32'd0;
          done_s       = 1'b0;
          error_s      = 1'b0;
          clear_s      = 1'b1;
        end else begin
          next_state_s = state_r;
        end
      end
      ST_HDR: begin
        if (word_ready_s) begin
          if ((word_next_s == 32'd0) || (word_next_s > 32'(MAX_WORDS))) begin
            next_state_s = ST_ERR;
            error_s      = 1'b1;
          end else begin
            next_state_s = ST_LOAD;
            n_s          = WCW'(word_next_s);
          end
        end else begin
          next_state_s = ST_HDR;
        end
      end
      ST_LOAD: begin
        if (word_ready_s) begin
          next_state_s = ST_WRITE;
          cs_s         = 1'b1;
          we_s         = 1'b1;
          addr_s       = word_addr(BASE_ADDR, 32'(k_r));
          din_s        = word_next_s;
          csum_s       = csum_r ^ word_next_s;
        end else begin
          next_state_s = ST_LOAD;
        end
      end
      ST_WRITE: begin
        if ((k_r + WCW'(1)) < n_r) begin
          next_state_s = ST_LOAD;
          k_s          = k_r + WCW'(1);
        end else begin
          next_state_s = ST_VRD;
          k_s          = '0;
          cs_s         = 1'b1;
          oe_s         = 1'b1;
          addr_s       = BASE_ADDR;
        end
      end
      ST_VRD: begin
        // Data for read k-1 arrives in the cycle read k is presented.
        if (k_r != '0) begin
          rb_s = rb_r ^ mem_dout;
        end else begin
          rb_s = rb_r;
        end
        if ((k_r + WCW'(1)) < n_r) begin
          next_state_s = ST_VRD;
          k_s          = k_r + WCW'(1);
          cs_s         = 1'b1;
          oe_s         = 1'b1;
          addr_s       = word_addr(BASE_ADDR, 32'(k_r + WCW'(1)));
        end else begin
          next_state_s = ST_VCHK;
          k_s          = '0;
        end
      end
      ST_VCHK: begin
        rb_s = rb_r ^ mem_dout;
        if ((rb_r ^ mem_dout) == csum_r) begin
          next_state_s = ST_DONE;
          done_s       = 1'b1;
        end else begin
          next_state_s = ST_ERR;
          error_s      = 1'b1;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and all outputs are registered from the next-state values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      k_r      <= '0;
      n_r      <= '0;
      csum_r   <= 32'd0;
      rb_r     <= 32'd0;
      in_ready <= 1'b0;
      mem_cs   <= 1'b0;
      mem_oe   <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= 32'd0;
      mem_din  <= 32'd0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state_r  <= next_state_s;
      k_r      <= k_s;
      n_r      <= n_s;
      csum_r   <= csum_s;
      rb_r     <= rb_s;
      in_ready <= (next_state_s == ST_HDR) || (next_state_s == ST_LOAD);
      mem_cs   <= cs_s;
      mem_oe   <= oe_s;
      mem_we   <= we_s;
      mem_addr <= addr_s;
      mem_din  <= din_s;
      cpu_hold <= !((next_state_s == ST_IDLE) || (next_state_s == ST_DONE));
      done     <= done_s;
      error    <= error_s;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader with a synchronous memory model
// that can corrupt word 1 on readback.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_ready;
  logic [7:0]  in_data;
  logic        mem_cs, mem_oe, mem_we, cpu_hold, done, error;
  logic [31:0] mem_addr, mem_din, mem_dout;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] mem [0:15];
  logic        corrupt;
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  int          rd_cnt;
  logic [31:0] exp_w [4];

  imem_loader #(.BASE_ADDR(32'h00000000), .MAX_WORDS(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mem_cs   (mem_cs),
    .mem_oe   (mem_oe),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  // Synchronous memory model with write log and read counter.
  always @(posedge clk) begin
    if (mem_cs && mem_we) begin
      mem[mem_addr[5:2]] <= mem_din;
      wa.push_back(mem_addr);
      wd.push_back(mem_din);
    end
    if (mem_cs && mem_oe) begin
      if (corrupt && (mem_addr[5:2] == 4'd1)) mem_dout <= mem[mem_addr[5:2]] ^ 32'h00000100;
      else mem_dout <= mem[mem_addr[5:2]];
      rd_cnt = rd_cnt + 1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    rd_cnt = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("ready_timeout", 32'(t < 50), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int i = 3; i >= 0; i--) begin
      if (gaps) repeat ($urandom_range(0, 1)) @(negedge clk);
      send_byte(w[8*i +: 8]);
    end
  endtask

  task automatic wait_status();
    int t = 0;
    while (!(done || error) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("status_timeout", 32'(t < 300), 32'd1);
  endtask

  task automatic check_writes(input string tag, input int n);
    check({tag, "_nwr"}, 32'(wa.size()), 32'(n));
    for (int i = 0; i < n && i < wa.size(); i++) begin
      check({tag, "_waddr"}, wa[i], 32'(4 * i));
      check({tag, "_wdata"}, wd[i], exp_w[i]);
    end
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    corrupt  = 1'b0;
    mem_dout = 32'd0;
    rd_cnt   = 0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_strobes", {29'd0, mem_cs, mem_oe, mem_we}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd0);
    check("rst_status", {30'd0, done, error}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Basic two-word load
    clear_log();
    pulse_start();
    check("a_hold_busy", 32'(cpu_hold), 32'd1);
    check("a_ready_hdr", 32'(in_ready), 32'd1);
    send_word(32'h00000002, 1'b0);
    send_word(32'h20010005, 1'b0);
    send_word(32'h00000000, 1'b0);
    wait_status();
    @(negedge clk);
    exp_w = '{32'h20010005, 32'h00000000, 32'h0, 32'h0};
    check_writes("a", 2);
    check("a_reads", 32'(rd_cnt), 32'd2);
    check("a_status", {30'd0, done, error}, 32'h2);
    check("a_hold", 32'(cpu_hold), 32'd0);
    check("a_strobes", {29'd0, mem_cs, mem_oe, mem_we}, 32'd0);

    // Zero-length header
    clear_log();
    pulse_start();
    check("b_done_cleared", 32'(done), 32'd0);
    send_word(32'h00000000, 1'b0);
    wait_status();
    repeat (2) @(negedge clk);
    check("b_status", {30'd0, done, error}, 32'h1);
    check("b_nwr", 32'(wa.size()), 32'd0);
    check("b_in_ready", 32'(in_ready), 32'd0);
    check("b_hold", 32'(cpu_hold), 32'd1);

    // Header one above the limit
    clear_log();
    pulse_start();
    send_word(32'h00000005, 1'b0);
    wait_status();
    repeat (2) @(negedge clk);
    check("c_status", {30'd0, done, error}, 32'h1);
    check("c_nwr", 32'(wa.size()), 32'd0);
    check("c_in_ready", 32'(in_ready), 32'd0);

    // Header exactly at the limit
    clear_log();
    pulse_start();
    check("c2_err_cleared", 32'(error), 32'd0);
    send_word(32'h00000004, 1'b0);
    exp_w = '{32'h01020304, 32'hF0E0D0C0, 32'h00FF00FF, 32'h80000001};
    for (int i = 0; i < 4; i++) send_word(exp_w[i], 1'b0);
    wait_status();
    @(negedge clk);
    check_writes("c2", 4);
    check("c2_reads", 32'(rd_cnt), 32'd4);
    check("c2_status", {30'd0, done, error}, 32'h2);

    // Readback corruption of word 1
    clear_log();
    corrupt = 1'b1;
    pulse_start();
    send_word(32'h00000002, 1'b0);
    send_word(32'hCAFEF00D, 1'b0);
    send_word(32'h0000ABCD, 1'b0);
    wait_status();
    repeat (2) @(negedge clk);
    check("d_status", {30'd0, done, error}, 32'h1);
    check("d_hold", 32'(cpu_hold), 32'd1);
    check("d_reads", 32'(rd_cnt), 32'd2);
    corrupt = 1'b0;

    // Three-word load, gap-free with an ignored start, then with random gaps
    exp_w = '{32'h11223344, 32'hA5A5A5A5, 32'hDEADBEEF, 32'h0};
    for (int run = 0; run < 2; run++) begin
      clear_log();
      pulse_start();
      send_word(32'h00000003, run == 1);
      if (run == 0) pulse_start();
      for (int i = 0; i < 3; i++) send_word(exp_w[i], run == 1);
      wait_status();
      @(negedge clk);
      check_writes(run == 0 ? "e_nogap" : "e_gap", 3);
      check("e_status", {30'd0, done, error}, 32'h2);
    end

    // Reset mid-load after byte 6, then full reload
    clear_log();
    pulse_start();
    send_word(32'h00000002, 1'b0);
    send_byte(8'h20);
    send_byte(8'h01);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("f_rst_hold", 32'(cpu_hold), 32'd0);
    check("f_rst_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    check("f_no_write", 32'(wa.size()), 32'd0);
    check("f_idle_status", {30'd0, done, error}, 32'h0);
    pulse_start();
    send_word(32'h00000002, 1'b0);
    exp_w = '{32'h12345678, 32'h9ABCDEF0, 32'h0, 32'h0};
    send_word(exp_w[0], 1'b0);
    send_word(exp_w[1], 1'b0);
    wait_status();
    @(negedge clk);
    check_writes("f", 2);
    check("f_status", {30'd0, done, error}, 32'h2);
    check("f_hold", 32'(cpu_hold), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
